adder_share_arb: RTL and testbench



---
 rtl/adder_share_arb_if.sv | 36 +++
 rtl/adder_share_arb.sv | 129 ++++++++++++
 tb/tb_adder_share_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arb_if.sv
// -----------------------------------------------------------------------------
// adder_share_arb_if
// Bundles the requester-side beat handshake and the result channel of the
// shared-adder arbiter.
//   master : requesters and result consumer (drive req_*, rsp_ready)
//   slave  : the arbiter (drives req_ready, rsp_*)
// Packing: requester i owns req_x/req_y bits [i*WIDTH +: WIDTH].
// -----------------------------------------------------------------------------
interface adder_share_arb_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = 3
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ*WIDTH-1:0] req_y;
   logic [NREQ-1:0]       req_cin;
   logic [NREQ-1:0]       req_more;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH:0]        rsp_sum;
   logic                  rsp_last;
   logic                  rsp_zero;

   modport master (
      output req_valid, req_x, req_y, req_cin, req_more, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_last, rsp_zero
   );

   modport slave (
      input  req_valid, req_x, req_y, req_cin, req_more, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_last, rsp_zero
   );
endinterface

// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
// Shares one WIDTH-bit adder among NREQ requesters. Round-robin grant in IDLE;
// a multi-beat (carry-chained) addition locks the grant to its owner until the
// beat with req_more=0. Result is a one-deep registered stage carrying the
// sum (with carry-out), requester id, last-beat flag and chain-wide zero flag.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : adder_share_arb_if.slave (req_* beat handshake, rsp_* result)
// -----------------------------------------------------------------------------
module adder_share_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = 3
) (
   input logic              clk,
   input logic              rst_n,
   adder_share_arb_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t          state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  lock_id_q;
   logic            carry_q;

   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [WIDTH:0]  rsp_sum_q;
   logic            rsp_last_q;
   logic            rsp_zero_q;

   logic [2*NREQ-1:0] valid_rot;
   logic [IDW-1:0]    rr_off;
   logic [IDW:0]      rr_wrap;
   logic [IDW-1:0]    rr_gnt;
   logic              rr_found;

   logic [IDW-1:0]  gnt;
   logic            has_gnt;
   logic [NREQ-1:0] gnt_oh;
   logic            slot_free;
   logic            accept;
   logic [WIDTH-1:0] op_x;
   logic [WIDTH-1:0] op_y;
   logic            cin;
   logic            more;
   logic [WIDTH:0]  sum;
   logic            zero;
   logic [IDW-1:0]  ptr_next;

   // Round-robin search: rotate req_valid so ptr lands on bit 0, then pick the
   // lowest set bit. The loop runs downward so the smallest offset wins.
   always_comb begin
      // NOTE: every variable gets a value before the loop so no latch is inferred.
      valid_rot = {bus.req_valid, bus.req_valid} >> ptr_q;
      rr_off    = '0;
      rr_found  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (valid_rot[k]) begin
            rr_off   = IDW'(k);
            rr_found = 1'b1;
         end
      end
      rr_wrap = {1'b0, ptr_q} + {1'b0, rr_off};
      rr_gnt  = (rr_wrap >= (IDW+1)'(NREQ)) ? IDW'(rr_wrap - (IDW+1)'(NREQ))
                                            : IDW'(rr_wrap);
   end

   // While LOCKED the owner keeps the grant even if it idles between beats.
   assign gnt       = (state_q == LOCKED) ? lock_id_q : rr_gnt;
   assign has_gnt   = (state_q == LOCKED) || rr_found;
   assign gnt_oh    = has_gnt ? (NREQ'(1) << gnt) : '0;
   assign slot_free = !rsp_valid_q || bus.rsp_ready;

   assign bus.req_ready = (rst_n && slot_free) ? gnt_oh : '0;
   assign accept        = |(bus.req_valid & bus.req_ready);

   // Operand mux and the single shared adder.
   assign op_x = WIDTH'(bus.req_x >> (int'(gnt) * WIDTH));
   assign op_y = WIDTH'(bus.req_y >> (int'(gnt) * WIDTH));
   assign cin  = (state_q == LOCKED) ? carry_q : |(bus.req_cin & gnt_oh);
   assign more = |(bus.req_more & gnt_oh);
   assign sum  = {1'b0, op_x} + {1'b0, op_y} + (WIDTH+1)'(cin);

   // rsp_zero_q still holds the previous beat of this chain while LOCKED.
   assign zero     = (sum[WIDTH-1:0] == '0) && ((state_q == IDLE) || rsp_zero_q);
   assign ptr_next = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         lock_id_q   <= '0;
         carry_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_last_q  <= 1'b0;
         rsp_zero_q  <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         rsp_valid_q <= 1'b1;
         rsp_id_q    <= gnt;
         rsp_sum_q   <= sum;
         rsp_last_q  <= !more;
         rsp_zero_q  <= zero;
         carry_q     <= sum[WIDTH];
         if (more) begin
            state_q   <= LOCKED;
            lock_id_q <= gnt;
         end else begin
            state_q   <= IDLE;
            ptr_q     <= ptr_next;
         end
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_last  = rsp_last_q;
   assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arb
// Directed scenarios followed by randomized multi-requester traffic. A
// behavioural model (round-robin over integer indices, chain carry and zero
// kept as plain variables) predicts grants and pushes expected results into a
// queue; an independent monitor pops and compares on every result transfer.
// -----------------------------------------------------------------------------
module tb_adder_share_arb;
   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int IDW   = 3;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [WIDTH:0] sum;
      logic           last;
      logic           zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adder_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_locked, m_carry, m_zero, m_busy;
   int m_lock, m_ptr;

   always @(negedge clk) begin : model
      bit              slot, has, acc, c;
      int              w;
      logic [NREQ-1:0] want;
      longint          x, y, s;
      exp_t            e;
      if (!rst_n) begin
         m_locked = 0; m_carry = 0; m_zero = 0; m_busy = 0;
         m_lock = 0; m_ptr = 0;
         exp_q.delete();
      end else begin
         slot = !m_busy || bus.rsp_ready;
         has  = 0;
         w    = 0;
         if (m_locked) begin
            has = 1;
            w   = m_lock;
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               if (!has && bus.req_valid[(m_ptr + k) % NREQ]) begin
                  has = 1;
                  w   = (m_ptr + k) % NREQ;
               end
            end
         end
         want = (slot && has) ? (NREQ'(1) << w) : '0;
         check("ready_grant", 64'(bus.req_ready & bus.req_valid), 64'(want & bus.req_valid));
         check("ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
         acc = slot && has && bus.req_valid[w];
         if (acc) begin
            x = longint'(bus.req_x[w*WIDTH +: WIDTH]);
            y = longint'(bus.req_y[w*WIDTH +: WIDTH]);
            c = m_locked ? m_carry : bus.req_cin[w];
            s = x + y + longint'(c);
            e.id   = IDW'(w);
            e.sum  = s[WIDTH:0];
            e.last = !bus.req_more[w];
            e.zero = (s[WIDTH-1:0] == '0) && (!m_locked || m_zero);
            exp_q.push_back(e);
            m_carry = s[WIDTH];
            m_zero  = e.zero;
            m_busy  = 1;
            if (bus.req_more[w]) begin
               m_locked = 1;
               m_lock   = w;
            end else begin
               m_locked = 0;
               m_ptr    = (w + 1) % NREQ;
            end
         end else if (bus.rsp_ready) begin
            m_busy = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_id",   64'(bus.rsp_id),   64'(e.id));
            check("rsp_sum",  64'(bus.rsp_sum),  64'(e.sum));
            check("rsp_last", 64'(bus.rsp_last), 64'(e.last));
            check("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_all();
      bus.req_valid = '0;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.req_cin   = '0;
      bus.req_more  = '0;
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic cin, input logic more);
      bus.req_valid[i]           = 1'b1;
      bus.req_x[i*WIDTH +: WIDTH] = x;
      bus.req_y[i*WIDTH +: WIDTH] = y;
      bus.req_cin[i]             = cin;
      bus.req_more[i]            = more;
   endtask

   // Returns at the falling edge where requester i sees req_ready (bounded).
   task automatic wait_ready(input int i, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.req_ready[i] && n < 50);
      check(name, 64'(bus.req_ready[i]), 64'd1);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [WIDTH-1:0] pick();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         2:       return WIDTH'($urandom_range(0, 3));
         default: return WIDTH'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int              beats_left[NREQ];
      bit              started[NREQ];
      logic [NREQ-1:0] hs;

      rst_n = 1'b0;
      idle_all();
      bus.rsp_ready = 1'b1;
      bus.req_valid = '1;
      #12;
      check("reset_req_ready", 64'(bus.req_ready), 64'd0);
      check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("reset_rsp_id",    64'(bus.rsp_id),    64'd0);
      check("reset_rsp_sum",   64'(bus.rsp_sum),   64'd0);
      check("reset_rsp_last",  64'(bus.rsp_last),  64'd0);
      check("reset_rsp_zero",  64'(bus.rsp_zero),  64'd0);
      bus.req_valid = '0;
      next_cycle();
      rst_n = 1'b1;

      // Single beat with carry-out, requester 2.
      set_req(2, '1, 1, 1'b0, 1'b0);
      wait_ready(2, "t1_grant");
      next_cycle();
      bus.req_valid[2] = 1'b0;
      @(negedge clk);
      check("t1_valid", 64'(bus.rsp_valid), 64'd1);
      check("t1_id",    64'(bus.rsp_id),    64'd2);
      check("t1_sum",   64'(bus.rsp_sum),   64'h1_0000_0000);
      check("t1_last",  64'(bus.rsp_last),  64'd1);
      check("t1_zero",  64'(bus.rsp_zero),  64'd1);

      // Two-beat chain, requester 1, carry propagates with no bubble.
      next_cycle();
      set_req(1, '1, 0, 1'b1, 1'b1);
      wait_ready(1, "t2_grant");
      next_cycle();
      set_req(1, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("t2_b1_ready", 64'(bus.req_ready), 64'b0010);
      check("t2_b0_sum",   64'(bus.rsp_sum),   64'h1_0000_0000);
      check("t2_b0_zero",  64'(bus.rsp_zero),  64'd1);
      check("t2_b0_last",  64'(bus.rsp_last),  64'd0);
      next_cycle();
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      check("t2_b1_sum",   64'(bus.rsp_sum),   64'd1);
      check("t2_b1_zero",  64'(bus.rsp_zero),  64'd0);
      check("t2_b1_last",  64'(bus.rsp_last),  64'd1);

      // All four continuously valid from ptr=0: grants rotate 0,1,2,3,...
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, pick(), pick(), 1'($urandom), 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("t3_rr_ready", 64'(bus.req_ready), 64'(1) << (k % NREQ));
         if (k > 0) check("t3_rr_id", 64'(bus.rsp_id), 64'((k - 1) % NREQ));
         next_cycle();
         for (int i = 0; i < NREQ; i++) set_req(i, pick(), pick(), 1'($urandom), 1'b0);
      end
      idle_all();

      // Requester 0 three-beat chain holds off requester 3.
      set_req(0, pick(), pick(), 1'($urandom), 1'b1);
      set_req(3, pick(), pick(), 1'($urandom), 1'b0);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         check("t4_lock_ready", 64'(bus.req_ready), 64'b0001);
         next_cycle();
         if (b < 2) set_req(0, pick(), pick(), 1'b0, (b == 0));
         else bus.req_valid[0] = 1'b0;
      end
      @(negedge clk);
      check("t4_r3_ready", 64'(bus.req_ready), 64'b1000);
      next_cycle();
      bus.req_valid[3] = 1'b0;
      set_req(0, pick(), pick(), 1'b0, 1'b0);
      set_req(1, pick(), pick(), 1'b0, 1'b0);
      @(negedge clk);
      check("t4_wrap_ready0", 64'(bus.req_ready), 64'b0001);
      next_cycle();
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      check("t4_wrap_ready1", 64'(bus.req_ready), 64'b0010);
      next_cycle();
      idle_all();

      // Back-pressure: result held, all ready low, then same-cycle accept.
      set_req(2, 5, 7, 1'b0, 1'b0);
      wait_ready(2, "t5_grant");
      next_cycle();
      bus.req_valid[2] = 1'b0;
      bus.rsp_ready    = 1'b0;
      set_req(1, 3, 4, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t5_hold_valid", 64'(bus.rsp_valid), 64'd1);
         check("t5_hold_id",    64'(bus.rsp_id),    64'd2);
         check("t5_hold_sum",   64'(bus.rsp_sum),   64'd12);
         check("t5_hold_ready", 64'(bus.req_ready), 64'd0);
         next_cycle();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_release_ready", 64'(bus.req_ready), 64'b0010);
      next_cycle();
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      check("t5_next_id",  64'(bus.rsp_id),  64'd1);
      check("t5_next_sum", 64'(bus.rsp_sum), 64'd8);
      next_cycle();

      // Reset in the middle of a chain owned by requester 2.
      set_req(2, '1, 1, 1'b0, 1'b1);
      wait_ready(2, "t6_grant");
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(bus.rsp_valid), 64'd0);
      check("t6_rst_sum",   64'(bus.rsp_sum),   64'd0);
      check("t6_rst_id",    64'(bus.rsp_id),    64'd0);
      check("t6_rst_zero",  64'(bus.rsp_zero),  64'd0);
      check("t6_rst_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      next_cycle();
      rst_n = 1'b1;
      set_req(1, 9, 9, 1'b0, 1'b0);
      set_req(2, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("t6_first_ready", 64'(bus.req_ready), 64'b0010);
      next_cycle();
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      check("t6_r2_ready", 64'(bus.req_ready), 64'b0100);
      check("t6_r1_id",    64'(bus.rsp_id),    64'd1);
      next_cycle();
      bus.req_valid[2] = 1'b0;
      @(negedge clk);
      check("t6_r2_id",   64'(bus.rsp_id),   64'd2);
      check("t6_r2_sum",  64'(bus.rsp_sum),  64'd0);
      check("t6_r2_zero", 64'(bus.rsp_zero), 64'd1);
      next_cycle();

      // Randomized traffic: chains of 1..4 beats, owner pauses, back-pressure.
      idle_all();
      for (int i = 0; i < NREQ; i++) begin
         beats_left[i] = 0;
         started[i]    = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         hs = bus.req_valid & bus.req_ready;
         next_cycle();
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
               beats_left[i]--;
               started[i] = (beats_left[i] != 0);
               if (beats_left[i] != 0)
                  set_req(i, pick(), pick(), 1'($urandom), beats_left[i] > 1);
            end
            if (beats_left[i] == 0 && $urandom_range(0, 3) == 0) begin
               beats_left[i] = $urandom_range(1, 4);
               started[i]    = 0;
               set_req(i, pick(), pick(), 1'($urandom), beats_left[i] > 1);
            end
            bus.req_valid[i] = (beats_left[i] != 0) && !(started[i] && $urandom_range(0, 4) == 0);
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end

      idle_all();
      bus.rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
